cpu_datapath: RTL and testbench

Register/bus/memory datapath that sits on the receiving end of the `control` block's strobe interface. It consumes every control strobe and returns `instruction`, `alu_carry` and `alu_zero` to the controller. It contains PC, MAR, 16×8 RAM, IR, A, B, ALU + flag register, output register and the shared 8-bit bus. A side-band programming port fills RAM before a run.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/cpu_datapath_alu.sv | 29 ++
 rtl/cpu_datapath.sv | 147 ++++++++++++++
 tb/tb_cpu_datapath.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the datapath and its controller.
//   DATA_W / ADDR_W : bus/register width and PC/MAR/RAM address width
//   OP_W            : opcode width (upper IR field)
//   opcode_t        : instruction opcodes held in IR[7:4]
package cpu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned OP_W   = DATA_W - ADDR_W;

  typedef enum logic [OP_W-1:0] {
    LDA = 4'h1,
    ADD = 4'h2,
    SUB = 4'h3,
    STA = 4'h4,
    LDI = 4'h5,
    JMP = 4'h6,
    JC  = 4'h7,
    JZ  = 4'h8,
    OUT = 4'hE,
    HLT = 4'hF
  } opcode_t;

endpackage

// File: rtl/cpu_datapath_alu.sv
// alu: combinational adder/subtractor for the datapath.
//   a, b      : operands (A and B registers)
//   subtract  : 0 -> a + b, 1 -> a + ~b + 1
//   result    : low DATA_W bits of the sum
//   carry     : sum bit DATA_W (for subtract, 1 means no borrow)
module alu
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              subtract,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   sum;

  always_comb begin
    b_op = subtract ? ~b : b;
    sum  = {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, subtract};
  end

  assign result = sum[DATA_W-1:0];
  assign carry  = sum[DATA_W];

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: PC, MAR, 16x8 RAM, IR, A, B, ALU + flags, output register
// and the shared bus, driven by the controller's strobes.
//   clk, rst (async, active high)
//   strobes  : pc_*, a_reg_*, b_reg_*, i_reg_*, mar_*, ram_*, alu_*, out_en
//   prog_*   : side-band RAM programming port (wins over a bus write)
//   instruction, alu_carry, alu_zero : to the controller
//   out_value, bus_value             : output register and live bus
//   bus_conflict : sticky multi-driver flag, only built when the macro
//                  DATAPATH_BUS_CHECK_EN is defined, otherwise tied 0
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pc_inc,
  input  logic                     pc_jump,
  input  logic                     pc_out,
  input  logic                     a_reg_read_from_bus,
  input  logic                     a_reg_write_to_bus,
  input  logic                     b_reg_read_from_bus,
  input  logic                     b_reg_write_to_bus,
  input  logic                     i_reg_read_from_bus,
  input  logic                     i_reg_write_to_bus,
  input  logic                     mar_read_from_bus,
  input  logic                     ram_read_from_bus,
  input  logic                     ram_write_to_bus,
  input  logic                     alu_out,
  input  logic                     alu_subtract,
  input  logic                     alu_flags_in,
  input  logic                     out_en,
  input  logic                     prog_we,
  input  logic [ADDR_W-1:0]        prog_addr,
  input  logic [DATA_W-1:0]        prog_data,
  output logic [DATA_W-ADDR_W-1:0] instruction,
  output logic                     alu_carry,
  output logic                     alu_zero,
  output logic [DATA_W-1:0]        out_value,
  output logic [DATA_W-1:0]        bus_value,
  output logic                     bus_conflict
);

  localparam int unsigned PAD_W = DATA_W - ADDR_W;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] out_reg;
  logic              carry_reg;
  logic              zero_reg;
  logic [DATA_W-1:0] ram [2**ADDR_W];
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic [DATA_W-1:0] bus;

  alu #(.DATA_W(DATA_W)) u_alu (
    .a        (a_reg),
    .b        (b_reg),
    .subtract (alu_subtract),
    .result   (alu_res),
    .carry    (alu_c)
  );

  assign ram_q = ram[mar];

  // Wired-OR bus: idle reads 0 and contention stays deterministic.
  always_comb begin
    bus = '0;
    if (pc_out)             bus = bus | {{PAD_W{1'b0}}, pc};
    if (a_reg_write_to_bus) bus = bus | a_reg;
    if (b_reg_write_to_bus) bus = bus | b_reg;
    if (i_reg_write_to_bus) bus = bus | {{PAD_W{1'b0}}, ir[ADDR_W-1:0]};
    if (ram_write_to_bus)   bus = bus | ram_q;
    if (alu_out)            bus = bus | alu_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      mar       <= '0;
      ir        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      out_reg   <= '0;
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      if (pc_jump)                  pc <= bus[ADDR_W-1:0];
      else if (pc_inc)              pc <= pc + 1'b1;
      if (mar_read_from_bus)   mar     <= bus[ADDR_W-1:0];
      if (i_reg_read_from_bus) ir      <= bus;
      if (a_reg_read_from_bus) a_reg   <= bus;
      if (b_reg_read_from_bus) b_reg   <= bus;
      if (out_en)              out_reg <= bus;
      if (alu_flags_in) begin
        carry_reg <= alu_c;
        zero_reg  <= (alu_res == '0);
      end
    end
  end

  // RAM contents are not cleared; reset only blocks writes while asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (prog_we) begin
      ram[prog_addr] <= prog_data;
    end else if (ram_read_from_bus) begin
      ram[mar] <= bus;
    end
  end

`ifdef DATAPATH_BUS_CHECK_EN
  logic [5:0] drivers;
  logic       multi_drive;
  logic       conflict_q;

  assign drivers = {pc_out, a_reg_write_to_bus, b_reg_write_to_bus,
                    i_reg_write_to_bus, ram_write_to_bus, alu_out};
  // More than one bit set <=> clearing the lowest set bit leaves a nonzero.
  assign multi_drive = |(drivers & (drivers - 6'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= 1'b0;
    end else if (multi_drive) begin
      conflict_q <= 1'b1;
      if (!conflict_q) $error("cpu_datapath: bus contention, drivers=%b", drivers);
    end
  end

  assign bus_conflict = conflict_q;
`else
  assign bus_conflict = 1'b0;
`endif

  assign instruction = ir[DATA_W-1:ADDR_W];
  assign alu_carry   = carry_reg;
  assign alu_zero    = zero_reg;
  assign out_value   = out_reg;
  assign bus_value   = bus;

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed bench for cpu_datapath. Stimulus pushes the
// expected observation into a scoreboard queue; a negedge monitor pops
// and compares against the DUT outputs.
module tb_cpu_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       pc_inc, pc_jump, pc_out;
  logic       a_reg_read_from_bus, a_reg_write_to_bus;
  logic       b_reg_read_from_bus, b_reg_write_to_bus;
  logic       i_reg_read_from_bus, i_reg_write_to_bus;
  logic       mar_read_from_bus, ram_read_from_bus, ram_write_to_bus;
  logic       alu_out, alu_subtract, alu_flags_in, out_en;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] instruction;
  logic       alu_carry, alu_zero, bus_conflict;
  logic [7:0] out_value, bus_value;

`ifdef DATAPATH_BUS_CHECK_EN
  localparam logic [7:0] CONF_EXP = 8'h01;
`else
  localparam logic [7:0] CONF_EXP = 8'h00;
`endif

  typedef enum int {OBS_BUS, OBS_INSTR, OBS_CARRY, OBS_ZERO, OBS_OUT, OBS_CONF} obs_t;
  typedef struct {
    obs_t       sel;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  cpu_datapath u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc_inc              (pc_inc),
    .pc_jump             (pc_jump),
    .pc_out              (pc_out),
    .a_reg_read_from_bus (a_reg_read_from_bus),
    .a_reg_write_to_bus  (a_reg_write_to_bus),
    .b_reg_read_from_bus (b_reg_read_from_bus),
    .b_reg_write_to_bus  (b_reg_write_to_bus),
    .i_reg_read_from_bus (i_reg_read_from_bus),
    .i_reg_write_to_bus  (i_reg_write_to_bus),
    .mar_read_from_bus   (mar_read_from_bus),
    .ram_read_from_bus   (ram_read_from_bus),
    .ram_write_to_bus    (ram_write_to_bus),
    .alu_out             (alu_out),
    .alu_subtract        (alu_subtract),
    .alu_flags_in        (alu_flags_in),
    .out_en              (out_en),
    .prog_we             (prog_we),
    .prog_addr           (prog_addr),
    .prog_data           (prog_data),
    .instruction         (instruction),
    .alu_carry           (alu_carry),
    .alu_zero            (alu_zero),
    .out_value           (out_value),
    .bus_value           (bus_value),
    .bus_conflict        (bus_conflict)
  );

  always #5 clk = ~clk;

  // Monitor: everything queued since the last negedge is checked here.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t       e;
      logic [7:0] act;
      e = sb.pop_front();
      case (e.sel)
        OBS_BUS:   act = bus_value;
        OBS_INSTR: act = {4'h0, instruction};
        OBS_CARRY: act = {7'h0, alu_carry};
        OBS_ZERO:  act = {7'h0, alu_zero};
        OBS_OUT:   act = out_value;
        default:   act = {7'h0, bus_conflict};
      endcase
      tests++;
      if (act !== e.val) begin
        fails++;
        $display("FAIL %s: got %02h, expected %02h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_obs(input obs_t s, input logic [7:0] v, input string n);
    exp_t e;
    e.sel  = s;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic clr();
    pc_inc = 0; pc_jump = 0; pc_out = 0;
    a_reg_read_from_bus = 0; a_reg_write_to_bus = 0;
    b_reg_read_from_bus = 0; b_reg_write_to_bus = 0;
    i_reg_read_from_bus = 0; i_reg_write_to_bus = 0;
    mar_read_from_bus = 0; ram_read_from_bus = 0; ram_write_to_bus = 0;
    alu_out = 0; alu_subtract = 0; alu_flags_in = 0; out_en = 0;
    prog_we = 0; prog_addr = '0; prog_data = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic mar_from_pc(input logic [7:0] pc_exp);
    pc_out = 1; mar_read_from_bus = 1;
    expect_obs(OBS_BUS, pc_exp, "pc_to_mar_bus");
    cyc();
  endtask

  // RAM[MAR] into A (0), B (1) or IR (2), then advance PC.
  task automatic ram_to(input int tgt, input logic [7:0] v);
    ram_write_to_bus = 1; pc_inc = 1;
    if (tgt == 0) a_reg_read_from_bus = 1;
    else if (tgt == 1) b_reg_read_from_bus = 1;
    else i_reg_read_from_bus = 1;
    expect_obs(OBS_BUS, v, "ram_to_reg_bus");
    cyc();
  endtask

  task automatic expect_cleared(input string n);
    expect_obs(OBS_INSTR, 8'h00, {n, "_instr"});
    expect_obs(OBS_OUT,   8'h00, {n, "_out"});
    expect_obs(OBS_CARRY, 8'h00, {n, "_carry"});
    expect_obs(OBS_ZERO,  8'h00, {n, "_zero"});
    expect_obs(OBS_CONF,  8'h00, {n, "_conflict"});
  endtask

  logic [7:0] prog_tbl [8] = '{8'h1E, 8'hFF, 8'h01, 8'h03, 8'h05, 8'h0F, 8'hF0, 8'h07};

  initial begin
    rst = 1;
    clr();
    @(posedge clk); #1;
    expect_cleared("reset");
    expect_obs(OBS_BUS, 8'h00, "idle_bus");
    cyc();
    rst = 0;

    for (int i = 0; i < 8; i++) begin
      prog_we = 1; prog_addr = i[3:0]; prog_data = prog_tbl[i];
      cyc();
    end
    rst = 1;
    cyc();
    rst = 0;

    // Fetch RAM[0]=1E into IR.
    mar_from_pc(8'h00);
    ram_to(2, 8'h1E);
    expect_obs(OBS_INSTR, 8'h01, "instruction");
    i_reg_write_to_bus = 1;
    expect_obs(OBS_BUS, 8'h0E, "ir_low_bus");
    cyc();

    // FF + 01 -> A=00, carry 1, zero 1.
    mar_from_pc(8'h01); ram_to(0, 8'hFF);
    mar_from_pc(8'h02); ram_to(1, 8'h01);
    alu_out = 1; a_reg_read_from_bus = 1; alu_flags_in = 1;
    expect_obs(OBS_BUS, 8'h00, "add_wrap_bus");
    cyc();
    expect_obs(OBS_CARRY, 8'h01, "add_wrap_carry");
    expect_obs(OBS_ZERO,  8'h01, "add_wrap_zero");
    a_reg_write_to_bus = 1;
    expect_obs(OBS_BUS, 8'h00, "a_after_add");
    cyc();

    // 3 - 5 -> FE, carry 0, zero 0; also 3 + 5 and 5 - 5.
    mar_from_pc(8'h03); ram_to(0, 8'h03);
    mar_from_pc(8'h04); ram_to(1, 8'h05);
    alu_out = 1; alu_subtract = 1; alu_flags_in = 1; out_en = 1;
    expect_obs(OBS_BUS, 8'hFE, "sub_bus");
    cyc();
    expect_obs(OBS_CARRY, 8'h00, "sub_carry");
    expect_obs(OBS_ZERO,  8'h00, "sub_zero");
    expect_obs(OBS_OUT,   8'hFE, "sub_out");
    alu_out = 1;
    expect_obs(OBS_BUS, 8'h08, "add_bus");
    cyc();
    b_reg_write_to_bus = 1; a_reg_read_from_bus = 1;
    expect_obs(OBS_BUS, 8'h05, "b_to_a_bus");
    cyc();
    alu_subtract = 1; alu_flags_in = 1;
    expect_obs(OBS_BUS, 8'h00, "flags_only_bus");
    cyc();
    expect_obs(OBS_CARRY, 8'h01, "sub_eq_carry");
    expect_obs(OBS_ZERO,  8'h01, "sub_eq_zero");

    // Two drivers OR together.
    mar_from_pc(8'h05); ram_to(0, 8'h0F);
    mar_from_pc(8'h06); ram_to(1, 8'hF0);
    a_reg_write_to_bus = 1; b_reg_write_to_bus = 1; out_en = 1;
    expect_obs(OBS_BUS, 8'hFF, "or_bus");
    cyc();
    expect_obs(OBS_OUT,  8'hFF, "or_out");
    expect_obs(OBS_CONF, CONF_EXP, "conflict_set");

    // Jump beats increment; pc_out with pc_inc shows the old PC.
    prog_we = 1; prog_addr = 4'h6; prog_data = 8'h07;
    cyc();
    ram_write_to_bus = 1; pc_jump = 1; pc_inc = 1;
    expect_obs(OBS_BUS, 8'h07, "jump_src_bus");
    cyc();
    pc_out = 1; pc_inc = 1;
    expect_obs(OBS_BUS, 8'h07, "pc_after_jump");
    cyc();
    pc_out = 1;
    expect_obs(OBS_BUS, 8'h08, "pc_after_inc");
    cyc();

    // Wrap: jump to 0, 15 increments -> F, one more -> 0.
    pc_jump = 1;
    cyc();
    for (int i = 0; i < 15; i++) begin
      pc_inc = 1;
      cyc();
    end
    pc_out = 1;
    expect_obs(OBS_BUS, 8'h0F, "pc_max");
    cyc();
    pc_inc = 1;
    cyc();
    pc_out = 1;
    expect_obs(OBS_BUS, 8'h00, "pc_wrap");
    cyc();

    // prog_we wins over a bus write to the same RAM word.
    for (int i = 0; i < 3; i++) begin
      pc_inc = 1;
      cyc();
    end
    mar_from_pc(8'h03);
    a_reg_write_to_bus = 1; ram_read_from_bus = 1;
    cyc();
    ram_write_to_bus = 1;
    expect_obs(OBS_BUS, 8'h0F, "ram_bus_write");
    cyc();
    prog_we = 1; prog_addr = 4'h3; prog_data = 8'hAA;
    a_reg_write_to_bus = 1; ram_read_from_bus = 1;
    cyc();
    ram_write_to_bus = 1;
    expect_obs(OBS_BUS, 8'hAA, "prog_priority");
    expect_obs(OBS_CONF, CONF_EXP, "conflict_sticky");
    cyc();

    // Reset mid-transfer: registers clear, RAM write aborted.
    rst = 1;
    a_reg_write_to_bus = 1; ram_read_from_bus = 1; out_en = 1;
    expect_cleared("midrun_reset");
    expect_obs(OBS_BUS, 8'h00, "midrun_a_cleared");
    cyc();
    rst = 0;
    b_reg_write_to_bus = 1;
    expect_obs(OBS_BUS, 8'h00, "b_cleared");
    cyc();
    for (int i = 0; i < 3; i++) begin
      pc_inc = 1;
      cyc();
    end
    mar_from_pc(8'h03);
    ram_write_to_bus = 1;
    expect_obs(OBS_BUS, 8'hAA, "ram_survives_reset");
    cyc();

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
